// File: rtl/icache_control.sv
// Control FSM for the 4-way instruction cache with next-line prefetch.
// It drives every mux select, write enable and load strobe of the datapath.
module icache_control #(
   parameter int NUM_WAYS = 4,
   parameter int LRU_W    = 3
) (
   input  logic                    clk,
   input  logic                    rst,
   input  logic                    mem_read,
   output logic                    mem_resp,
   output logic                    pmem_read,
   input  logic                    pmem_resp,
   input  logic [NUM_WAYS-1:0]     hit_o,
   input  logic [NUM_WAYS-1:0]     valid_o,
   input  logic [LRU_W-1:0]        lru_o,
   input  logic [NUM_WAYS-1:0]     nhit_o,
   input  logic [NUM_WAYS-1:0]     nvalid_o,
   input  logic [LRU_W-1:0]        nlru_o,
   input  logic                    pref_hit,
   output logic                    load_prefetch_line,
   output logic                    dimux_sel,
   output logic [1:0]              domux_sel,
   output logic                    paddrmux_sel,
   output logic                    addrmux_sel,
   output logic [2*NUM_WAYS-1:0]   wemux_sel,
   output logic [2*NUM_WAYS-1:0]   nwemux_sel,
   output logic                    lru_load,
   output logic                    nlru_load,
   output logic [LRU_W-1:0]        lru_i,
   output logic [NUM_WAYS-1:0]     valid_load,
   output logic [NUM_WAYS-1:0]     nvalid_load,
   output logic [NUM_WAYS-1:0]     tag_load,
   output logic [NUM_WAYS-1:0]     ntag_load,
   output logic [NUM_WAYS-1:0]     valid_i,
   output logic [NUM_WAYS-1:0]     nvalid_i,
   output logic [NUM_WAYS-1:0]     dirty_load,
   output logic [NUM_WAYS-1:0]     ndirty_load,
   output logic [NUM_WAYS-1:0]     dirty_i,
   output logic [NUM_WAYS-1:0]     ndirty_i
);

   // Select encodings shared with the datapath.
   localparam logic       DI_CPU    = 1'b0;  // mem_wdata256_from_cpu
   localparam logic       DI_PMEM   = 1'b1;  // pmem_rdata_from_mem
   localparam logic       PA_CPU    = 1'b0;  // cpu line
   localparam logic       PA_PREF   = 1'b1;  // prefetch_line
   localparam logic       AD_CPU    = 1'b0;
   localparam logic [1:0] WE_ONES   = 2'b10;

   typedef enum logic [1:0] {IDLE, FILL, RESP, PREF_FILL} state_t;

   state_t     state, state_d;
   logic       pref_busy, pref_busy_d;
   logic [1:0] nvictim, nvictim_d;
   logic [1:0] hit_way, victim;
   logic       serve;

   // A stalled miss behaves the same whether or not it targets the pending
   // prefetch line: once back in IDLE the arrays tell hit from miss.
   logic unused_pref_hit;
   assign unused_pref_hit = pref_hit;

   function automatic logic [1:0] pick_victim(input logic [NUM_WAYS-1:0] v,
                                              input logic [LRU_W-1:0] l);
      logic [1:0] w;
      if (l[0] == 1'b0) w = l[1] ? 2'd1 : 2'd0;
      else              w = l[2] ? 2'd3 : 2'd2;
      for (int i = NUM_WAYS - 1; i >= 0; i--)
         if (!v[i]) w = 2'(i);
      return w;
   endfunction

   function automatic logic [LRU_W-1:0] touch(input logic [1:0] w,
                                              input logic [LRU_W-1:0] l);
      case (w)
         2'd0:    return {l[2], 1'b1, 1'b1};
         2'd1:    return {l[2], 1'b0, 1'b1};
         2'd2:    return {1'b1, l[1], 1'b0};
         default: return {1'b0, l[1], 1'b0};
      endcase
   endfunction

   always_comb begin
      hit_way = 2'd0;
      for (int i = NUM_WAYS - 1; i >= 0; i--)
         if (hit_o[i]) hit_way = 2'(i);
   end

   assign victim = pick_victim(valid_o, lru_o);
   assign serve  = rst && mem_read && (|hit_o) && (state != FILL);

   always_ff @(posedge clk) begin
      if (!rst) begin
         state     <= IDLE;
         pref_busy <= 1'b0;
         nvictim   <= 2'd0;
      end else begin
         state     <= state_d;
         pref_busy <= pref_busy_d;
         nvictim   <= nvictim_d;
      end
   end

   always_comb begin
      state_d            = state;
      pref_busy_d        = pref_busy;
      nvictim_d          = nvictim;
      mem_resp           = 1'b0;
      pmem_read          = 1'b0;
      load_prefetch_line = 1'b0;
      dimux_sel          = DI_CPU;
      domux_sel          = 2'd0;
      paddrmux_sel       = PA_CPU;
      addrmux_sel        = AD_CPU;
      wemux_sel          = '0;
      nwemux_sel         = '0;
      lru_load           = 1'b0;
      nlru_load          = 1'b0;
      lru_i              = '0;
      valid_load         = '0;
      nvalid_load        = '0;
      tag_load           = '0;
      ntag_load          = '0;
      valid_i            = '0;
      nvalid_i           = '0;
      dirty_load         = '0;
      ndirty_load        = '0;
      dirty_i            = '0;
      ndirty_i           = '0;

      if (rst) begin
         case (state)
            IDLE: begin
               if (mem_read && !(|hit_o)) state_d = FILL;
            end
            FILL: begin
               pmem_read    = 1'b1;
               paddrmux_sel = PA_CPU;
               if (pmem_resp) begin
                  dimux_sel                 = DI_PMEM;
                  wemux_sel[{victim, 1'b0} +: 2] = WE_ONES;
                  tag_load[victim]          = 1'b1;
                  valid_load[victim]        = 1'b1;
                  valid_i[victim]           = 1'b1;
                  state_d                   = RESP;
               end
            end
            RESP: begin
               load_prefetch_line = 1'b1;
               if (|nhit_o) begin
                  state_d = IDLE;
               end else begin
                  nvictim_d   = pick_victim(nvalid_o, nlru_o);
                  pref_busy_d = 1'b1;
                  state_d     = PREF_FILL;
               end
            end
            PREF_FILL: begin
               pmem_read    = 1'b1;
               paddrmux_sel = pref_busy ? PA_PREF : PA_CPU;
               if (pmem_resp) begin
                  nwemux_sel[{nvictim, 1'b0} +: 2] = WE_ONES;
                  ntag_load[nvictim]        = 1'b1;
                  nvalid_load[nvictim]      = 1'b1;
                  nvalid_i[nvictim]         = 1'b1;
                  pref_busy_d               = 1'b0;
                  state_d                   = IDLE;
               end
            end
            default: state_d = IDLE;
         endcase
      end

      if (serve) begin
         mem_resp  = 1'b1;
         domux_sel = hit_way;
         lru_load  = 1'b1;
         lru_i     = touch(hit_way, lru_o);
      end
   end

endmodule

// File: doc/icache_control.md
Name: icache_control

Overview:
- Controller FSM that sequences the 4-way instruction-cache datapath with next-line prefetch.
- Serves CPU fetch hits in a single cycle and fills misses from physical memory.
- After each demand fill, prefetches line+32 B into the same cache through the datapath's second (next-line) array port.
- Sits between the fetch-side bus adaptor and the cacheline adaptor, driving every select and load of the datapath.

Parameters:
- NUM_WAYS, 4, associativity; fixed, other values unsupported.
- LRU_W, 3, pseudo-LRU tree bits per set.

Ports:
- clk  in  1  clock
- rst  in  1  synchronous active-low reset (0 = reset)
- mem_read  in  1  CPU fetch request, held until mem_resp
- mem_resp  out  1  fetch complete (rdata valid this cycle)
- pmem_read  out  1  physical memory read request
- pmem_resp  in  1  physical memory line returned
- hit_o  in  4  per-way hit, current set
- valid_o  in  4  per-way valid, current set
- lru_o  in  3  PLRU bits, current set
- nhit_o  in  4  per-way hit, next-line set
- nvalid_o  in  4  per-way valid, next-line set
- nlru_o  in  3  PLRU bits, next-line set
- pref_hit  in  1  CPU address matches latched prefetch line
- load_prefetch_line  out  1  latch next-line address/tag/set in datapath
- dimux_sel, domux_sel, paddrmux_sel, addrmux_sel  out  enum  datapath mux selects
- wemux_sel, nwemux_sel  out  4 x enum  per-way data write enables
- lru_load, nlru_load  out  1  PLRU write strobes
- lru_i  out  3  PLRU write data
- valid_load, nvalid_load, tag_load, ntag_load  out  4  per-way loads
- valid_i, nvalid_i  out  4  valid write data
- dirty_load, ndirty_load  out  4  tied 0
- dirty_i, ndirty_i  out  4  tied 0

Behaviour:
- Contract: array reads are combinational on the addressed set; writes commit on the clk edge. While paddrmux_sel = prefetch_line, the datapath indexes the next port with the latched prefetch set.
- States: IDLE, FILL, RESP, PREF_FILL.
- Reset (rst = 0 at edge): state IDLE, pref_busy = 0, nvictim = 0.
- Reset outputs: all outputs 0 / zeros; domux_sel = data_array_0; dimux_sel = mem_wdata256_from_cpu.
- Reset mid-fill: pmem_read drops the next cycle; no array write occurs.
- Hit (any state except FILL, mem_read & |hit_o):
  - mem_resp = 1 in the same cycle.
  - domux_sel = hit way.
  - lru_load = 1, lru_i = touched(way).
- PLRU touch encoding, as (bit0, bit1, bit2 written; other bit kept):
  - way0: 1, 1, keep
  - way1: 1, 0, keep
  - way2: 0, keep, 1
  - way3: 0, keep, 0
- Victim selection:
  - The lowest-index invalid way wins.
  - Otherwise: if bit0 = 0, victim = bit1 ? way1 : way0; if bit0 = 1, victim = bit2 ? way3 : way2.
- IDLE, mem_read & no hit -> FILL, pmem_read = 1 from the next cycle.
- FILL:
  - pmem_read = 1, paddrmux_sel = cpu line.
  - On pmem_resp: dimux_sel = pmem_rdata_from_mem, wemux_sel[victim] = ones, tag_load[victim] = 1, valid_load[victim] = 1, valid_i[victim] = 1; -> RESP.
- RESP (line now hits):
  - Hit response as above.
  - load_prefetch_line = 1.
  - If |nhit_o -> IDLE; else latch nvictim from nvalid_o/nlru_o, set pref_busy = 1, -> PREF_FILL.
- PREF_FILL:
  - pmem_read = 1, paddrmux_sel = prefetch_line.
  - On pmem_resp: nwemux_sel[nvictim] = ones, ntag_load[nvictim] = 1, nvalid_load[nvictim] = 1, nvalid_i = 1; pref_busy = 0; -> IDLE.
  - nlru_load is never asserted; the prefetched line is not promoted.
  - CPU hits are served concurrently.
  - A CPU miss (pref_hit or not) stalls: no mem_resp until IDLE. It then resolves as a hit (pref_hit) or a new FILL.
- pmem_read stays high continuously until pmem_resp. A transaction is never aborted.
- At most one memory transaction is outstanding at any time.

Test Plan:
- Cold miss 0x0000_0040, all invalid -> pmem_read in FILL, fill way0 on pmem_resp, mem_resp in RESP, then PREF_FILL of 0x60 into next-set way0.
- Fetch 0x60 after the prefetch completes -> single-cycle hit (mem_resp same cycle), no pmem_read.
- Set full with lru = 3'b000 and a miss -> victim way0 replaced; lru_i = 3'b011 in RESP.
- Miss to 0x60 while PREF_FILL of 0x60 is pending (pref_hit = 1) -> mem_resp held low until IDLE, then a hit with no second pmem_read.
- Hit to a resident line during PREF_FILL -> mem_resp same cycle while pmem_read stays 1.
- rst = 0 during FILL -> next cycle state IDLE, pmem_read = 0, no valid_load or tag_load pulse.
